// File: rtl/if_id_skid_stage.sv
// IF/ID pipeline stage: {pc, instr} register with a 2-entry skid buffer, registered in_ready,
// synchronous flush and NOP on empty. Optional perf counters behind `IF_ID_PERF_CNT_EN.
module if_id_skid_stage #(
   parameter int unsigned          PC_W      = 16,
   parameter int unsigned          INSTR_W   = 16,
   parameter logic [INSTR_W-1:0]   NOP_INSTR = 16'h0000
`ifdef IF_ID_PERF_CNT_EN
   ,
   parameter int unsigned          CNT_W     = 32
`endif
) (
   input  logic               clk,
   input  logic               rst_n,
   input  logic               in_valid,
   output logic               in_ready,
   input  logic [PC_W-1:0]    in_pc,
   input  logic [INSTR_W-1:0] in_instr,
   output logic               out_valid,
   input  logic               out_ready,
   output logic [PC_W-1:0]    out_pc,
   output logic [INSTR_W-1:0] out_instr,
   output logic [3:0]         out_opcode,
   input  logic               flush,
   output logic [1:0]         occupancy
`ifdef IF_ID_PERF_CNT_EN
   ,
   input  logic               cnt_clr,
   output logic [CNT_W-1:0]   stall_cnt,
   output logic [CNT_W-1:0]   bubble_cnt,
   output logic [CNT_W-1:0]   flush_cnt
`endif
);

   logic               r_main_valid, w_main_valid_d;
   logic [PC_W-1:0]    r_main_pc, w_main_pc_d;
   logic [INSTR_W-1:0] r_main_instr, w_main_instr_d;
   logic               r_skid_valid, w_skid_valid_d;
   logic [PC_W-1:0]    r_skid_pc, w_skid_pc_d;
   logic [INSTR_W-1:0] r_skid_instr, w_skid_instr_d;
   logic               r_in_ready;
   logic               w_accept;
   logic               w_drain;

   assign w_accept = in_valid & r_in_ready;
   assign w_drain  = r_main_valid & out_ready;

   always_comb begin
      w_main_valid_d = r_main_valid;
      w_main_pc_d    = r_main_pc;
      w_main_instr_d = r_main_instr;
      w_skid_valid_d = r_skid_valid;
      w_skid_pc_d    = r_skid_pc;
      w_skid_instr_d = r_skid_instr;
      if (flush) begin
         // Payload is left in place; only the valids matter after a flush.
         w_main_valid_d = 1'b0;
         w_skid_valid_d = 1'b0;
      end else if (!r_main_valid) begin
         if (w_accept) begin
            w_main_valid_d = 1'b1;
            w_main_pc_d    = in_pc;
            w_main_instr_d = in_instr;
         end
      end else if (!r_skid_valid) begin
         if (w_accept && w_drain) begin
            w_main_pc_d    = in_pc;
            w_main_instr_d = in_instr;
         end else if (w_accept) begin
            w_skid_valid_d = 1'b1;
            w_skid_pc_d    = in_pc;
            w_skid_instr_d = in_instr;
         end else if (w_drain) begin
            w_main_valid_d = 1'b0;
         end
      end else if (w_drain) begin
         w_main_pc_d    = r_skid_pc;
         w_main_instr_d = r_skid_instr;
         w_skid_valid_d = 1'b0;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_main_valid <= 1'b0;
         r_main_pc    <= '0;
         r_main_instr <= '0;
         r_skid_valid <= 1'b0;
         r_skid_pc    <= '0;
         r_skid_instr <= '0;
         r_in_ready   <= 1'b1;
      end else begin
         r_main_valid <= w_main_valid_d;
         r_main_pc    <= w_main_pc_d;
         r_main_instr <= w_main_instr_d;
         r_skid_valid <= w_skid_valid_d;
         r_skid_pc    <= w_skid_pc_d;
         r_skid_instr <= w_skid_instr_d;
         r_in_ready   <= ~w_skid_valid_d;
      end
   end

   assign in_ready   = r_in_ready;
   assign out_valid  = r_main_valid;
   assign out_pc     = r_main_pc;
   assign out_instr  = r_main_valid ? r_main_instr : NOP_INSTR;
   assign out_opcode = out_instr[15:12];
   assign occupancy  = {1'b0, r_main_valid} + {1'b0, r_skid_valid};

`ifdef IF_ID_PERF_CNT_EN
   logic [CNT_W-1:0] r_stall_cnt;
   logic [CNT_W-1:0] r_bubble_cnt;
   logic [CNT_W-1:0] r_flush_cnt;
   logic             w_stall_inc;
   logic             w_bubble_inc;
   logic             w_flush_inc;

   assign w_stall_inc  = r_main_valid & ~out_ready & (r_stall_cnt != '1);
   assign w_bubble_inc = ~r_main_valid & (r_bubble_cnt != '1);
   assign w_flush_inc  = flush & (occupancy != 2'd0) & (r_flush_cnt != '1);

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_stall_cnt  <= '0;
         r_bubble_cnt <= '0;
         r_flush_cnt  <= '0;
      end else if (cnt_clr) begin
         r_stall_cnt  <= '0;
         r_bubble_cnt <= '0;
         r_flush_cnt  <= '0;
      end else begin
         if (w_stall_inc)  r_stall_cnt  <= r_stall_cnt + CNT_W'(1);
         if (w_bubble_inc) r_bubble_cnt <= r_bubble_cnt + CNT_W'(1);
         if (w_flush_inc)  r_flush_cnt  <= r_flush_cnt + CNT_W'(1);
      end
   end

   assign stall_cnt  = r_stall_cnt;
   assign bubble_cnt = r_bubble_cnt;
   assign flush_cnt  = r_flush_cnt;
`endif

endmodule

// File: tb/tb_if_id_skid_stage.sv
// Directed bench for if_id_skid_stage; counter checks compile in with `IF_ID_PERF_CNT_EN.
module tb_if_id_skid_stage;

   logic        clk = 1'b0;
   logic        rst_n;
   logic        in_valid;
   logic        in_ready;
   logic [15:0] in_pc;
   logic [15:0] in_instr;
   logic        out_valid;
   logic        out_ready;
   logic [15:0] out_pc;
   logic [15:0] out_instr;
   logic [3:0]  out_opcode;
   logic        flush;
   logic [1:0]  occupancy;
`ifdef IF_ID_PERF_CNT_EN
   logic        cnt_clr;
   logic [31:0] stall_cnt;
   logic [31:0] bubble_cnt;
   logic [31:0] flush_cnt;
`endif

   int n_vec = 0;
   int n_err = 0;

   always #5 clk = ~clk;

   if_id_skid_stage dut (
      .clk        (clk),
      .rst_n      (rst_n),
      .in_valid   (in_valid),
      .in_ready   (in_ready),
      .in_pc      (in_pc),
      .in_instr   (in_instr),
      .out_valid  (out_valid),
      .out_ready  (out_ready),
      .out_pc     (out_pc),
      .out_instr  (out_instr),
      .out_opcode (out_opcode),
      .flush      (flush),
      .occupancy  (occupancy)
`ifdef IF_ID_PERF_CNT_EN
      ,
      .cnt_clr    (cnt_clr),
      .stall_cnt  (stall_cnt),
      .bubble_cnt (bubble_cnt),
      .flush_cnt  (flush_cnt)
`endif
   );

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic check_state(input string name, input logic exp_ov, input logic [15:0] exp_pc,
                              input logic [15:0] exp_instr, input logic exp_ir,
                              input logic [1:0] exp_occ);
      n_vec++;
      if ({out_valid, out_pc, out_instr, out_opcode, in_ready, occupancy} !==
          {exp_ov, exp_pc, exp_instr, exp_instr[15:12], exp_ir, exp_occ}) begin
         n_err++;
         $display("FAIL %s: got v=%b pc=%h instr=%h op=%h rdy=%b occ=%0d, want v=%b pc=%h instr=%h op=%h rdy=%b occ=%0d",
                  name, out_valid, out_pc, out_instr, out_opcode, in_ready, occupancy,
                  exp_ov, exp_pc, exp_instr, exp_instr[15:12], exp_ir, exp_occ);
      end
   endtask

   task automatic test_reset();
      rst_n = 1'b0; in_valid = 1'b0; in_pc = '0; in_instr = '0; out_ready = 1'b0; flush = 1'b0;
`ifdef IF_ID_PERF_CNT_EN
      cnt_clr = 1'b0;
`endif
      repeat (2) tick();
      check_state("reset", 1'b0, 16'h0000, 16'h0000, 1'b1, 2'd0);
      rst_n = 1'b1;
      repeat (2) tick();
      check_state("idle", 1'b0, 16'h0000, 16'h0000, 1'b1, 2'd0);
   endtask

   task automatic test_stream();
      logic [15:0] pcs [3] = '{16'h3000, 16'h3002, 16'h3004};
      logic [15:0] ins [3] = '{16'h1261, 16'h5020, 16'h0E02};
      out_ready = 1'b1;
      for (int i = 0; i < 3; i++) begin
         in_valid = 1'b1; in_pc = pcs[i]; in_instr = ins[i];
         tick();
         check_state($sformatf("stream%0d", i), 1'b1, pcs[i], ins[i], 1'b1, 2'd1);
      end
      in_valid = 1'b0;
      tick();
      check_state("stream_drain", 1'b0, 16'h3004, 16'h0000, 1'b1, 2'd0);
   endtask

   task automatic test_backpressure();
      out_ready = 1'b0;
      in_valid = 1'b1; in_pc = 16'h3000; in_instr = 16'h1261;
      tick();
      check_state("bp_first", 1'b1, 16'h3000, 16'h1261, 1'b1, 2'd1);
      in_pc = 16'h3002; in_instr = 16'h5020;
      tick();
      check_state("bp_full", 1'b1, 16'h3000, 16'h1261, 1'b0, 2'd2);
      in_pc = 16'h3004; in_instr = 16'h0E02;
      tick();
      check_state("bp_refuse", 1'b1, 16'h3000, 16'h1261, 1'b0, 2'd2);
      in_valid = 1'b0; out_ready = 1'b1;
      #1;
      check_state("bp_head", 1'b1, 16'h3000, 16'h1261, 1'b0, 2'd2);
      tick();
      check_state("bp_second", 1'b1, 16'h3002, 16'h5020, 1'b1, 2'd1);
      tick();
      check_state("bp_empty", 1'b0, 16'h3002, 16'h0000, 1'b1, 2'd0);
   endtask

   task automatic fill_two();
      out_ready = 1'b0; in_valid = 1'b1;
      in_pc = 16'h3000; in_instr = 16'h1261;
      tick();
      in_pc = 16'h3002; in_instr = 16'h5020;
      tick();
      in_valid = 1'b0;
   endtask

   task automatic test_flush();
      fill_two();
      check_state("fl_pre", 1'b1, 16'h3000, 16'h1261, 1'b0, 2'd2);
      flush = 1'b1; in_valid = 1'b1; in_pc = 16'h3004; in_instr = 16'h0E02; out_ready = 1'b1;
      tick();
      check_state("fl_cleared", 1'b0, 16'h3000, 16'h0000, 1'b1, 2'd0);
      flush = 1'b0; in_valid = 1'b0;
      repeat (2) tick();
      check_state("fl_no_ghost", 1'b0, 16'h3000, 16'h0000, 1'b1, 2'd0);
   endtask

   task automatic test_async_reset();
      fill_two();
      check_state("ar_pre", 1'b1, 16'h3000, 16'h1261, 1'b0, 2'd2);
      #2 rst_n = 1'b0;
      #1;
      check_state("ar_async", 1'b0, 16'h0000, 16'h0000, 1'b1, 2'd0);
      tick();
      rst_n = 1'b1;
      out_ready = 1'b1;
      repeat (2) tick();
      check_state("ar_after", 1'b0, 16'h0000, 16'h0000, 1'b1, 2'd0);
   endtask

`ifdef IF_ID_PERF_CNT_EN
   task automatic test_perf_cnt();
      in_valid = 1'b0; out_ready = 1'b0; flush = 1'b0; cnt_clr = 1'b1;
      tick();
      cnt_clr = 1'b0; in_valid = 1'b1; in_pc = 16'h3000; in_instr = 16'h1261;
      tick();
      in_valid = 1'b0;
      repeat (5) tick();
      flush = 1'b1; out_ready = 1'b1;
      tick();
      flush = 1'b0;
      repeat (3) tick();
      n_vec++;
      if (stall_cnt !== 32'd5) begin
         n_err++; $display("FAIL stall_cnt: got %0d want 5", stall_cnt);
      end
      n_vec++;
      if (bubble_cnt !== 32'd4) begin
         n_err++; $display("FAIL bubble_cnt: got %0d want 4", bubble_cnt);
      end
      n_vec++;
      if (flush_cnt !== 32'd1) begin
         n_err++; $display("FAIL flush_cnt: got %0d want 1", flush_cnt);
      end
      cnt_clr = 1'b1;
      tick();
      cnt_clr = 1'b0;
      n_vec++;
      if ({stall_cnt, bubble_cnt, flush_cnt} !== 96'd0) begin
         n_err++;
         $display("FAIL cnt_clr: got %0d/%0d/%0d want 0/0/0", stall_cnt, bubble_cnt, flush_cnt);
      end
   endtask
`endif

   initial begin
      test_reset();
      test_stream();
      test_backpressure();
      test_flush();
      test_async_reset();
`ifdef IF_ID_PERF_CNT_EN
      test_perf_cnt();
`endif
      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
